instr_mem_tl_bridge: RTL

INSTR_MEM_TL_BRIDGE -- requirements
Module: instr_mem_tl_bridge

---
 rtl/tlul_pkg.sv | 37 +++
 rtl/instr_mem_tl_bridge.sv | 133 +++++++++++++
 2 files changed

// File: rtl/tlul_pkg.sv
// Shared TL-UL encodings, field widths and bridge FSM states.
// Imported by the instruction-memory TL-UL bridge.
package tlul_pkg;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_MW  = TL_DW / 8;
  localparam int TL_SZW = 2;
  localparam int TL_OPW = 3;
  localparam int IM_AW  = 12;

  typedef enum logic [TL_OPW-1:0] {
    PutFullData    = 3'd0,
    PutPartialData = 3'd1,
    Get            = 3'd4
  } tl_a_op_e;

  typedef enum logic [TL_OPW-1:0] {
    AccessAck     = 3'd0,
    AccessAckData = 3'd1
  } tl_d_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } br_state_e;

  function automatic logic tl_a_op_legal(
    input logic [TL_OPW-1:0] op
  );
    return (op == PutFullData) ||
           (op == PutPartialData) ||
           (op == Get);
  endfunction

endpackage

// File: rtl/instr_mem_tl_bridge.sv
// TL-UL slave bridge onto a 16 KiB word-addressed instruction memory.
// Ports: clock/reset, TL-UL A and D channels, memory req/addr/wdata/we/rdata/rvalid.
module instr_mem_tl_bridge
  import tlul_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          SRC_W     = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [2:0]        a_opcode,
  input  logic [1:0]        a_size,
  input  logic [3:0]        a_mask,
  input  logic [31:0]       a_address,
  input  logic [31:0]       a_data,
  input  logic [SRC_W-1:0]  a_source,
  output logic              d_valid,
  input  logic              d_ready,
  output logic [2:0]        d_opcode,
  output logic [1:0]        d_size,
  output logic [SRC_W-1:0]  d_source,
  output logic [31:0]       d_data,
  output logic              d_error,
  output logic              req,
  output logic [11:0]       addr,
  output logic [31:0]       wdata,
  output logic [3:0]        we,
  input  logic [31:0]       rdata,
  input  logic              rvalid
);

  br_state_e        r_state;
  logic             r_is_get;
  logic             r_d_valid;
  tl_d_op_e         r_d_opcode;
  logic [1:0]       r_d_size;
  logic [SRC_W-1:0] r_d_source;
  logic [31:0]      r_d_data;
  logic             r_d_error;

  logic w_is_get;
  logic w_is_pf;
  logic w_is_pp;
  logic w_err;
  logic w_hs;
  logic w_req;

  assign w_is_get = (a_opcode == Get);
  assign w_is_pf  = (a_opcode == PutFullData);
  assign w_is_pp  = (a_opcode == PutPartialData);

  assign w_err = !tl_a_op_legal(a_opcode) ||
                 (a_address[31:14] != BASE_ADDR[31:14]) ||
                 (a_address[1:0] != 2'b00) ||
                 (a_size != 2'd2) ||
                 (w_is_pf && (a_mask != 4'hF)) ||
                 (w_is_pp && (a_mask == 4'h0));

  // Gate with reset so nothing is accepted while reset is held.
  assign a_ready = reset && (r_state == ST_IDLE);
  assign w_hs    = a_valid && a_ready;
  assign w_req   = w_hs && !w_err;

  assign req   = w_req;
  assign addr  = w_req ? a_address[13:2] : '0;
  assign wdata = w_req ? a_data : '0;
  assign we    = (w_req && !w_is_get) ? a_mask : '0;

  assign d_valid  = r_d_valid;
  assign d_opcode = r_d_opcode;
  assign d_size   = r_d_size;
  assign d_source = r_d_source;
  assign d_data   = r_d_data;
  assign d_error  = r_d_error;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_is_get   <= 1'b0;
      r_d_valid  <= 1'b0;
      r_d_opcode <= AccessAck;
      r_d_size   <= '0;
      r_d_source <= '0;
      r_d_data   <= '0;
      r_d_error  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            r_d_opcode <= w_is_get ? AccessAckData : AccessAck;
            r_d_size   <= a_size;
            r_d_source <= a_source;
            r_is_get   <= w_is_get;
            if (w_err) begin
              // Rejected requests skip memory and answer next cycle.
              r_d_valid <= 1'b1;
              r_d_error <= 1'b1;
              r_d_data  <= '0;
              r_state   <= ST_RESP;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          r_d_valid <= 1'b1;
          r_state   <= ST_RESP;
          if (r_is_get && rvalid) begin
            r_d_data  <= rdata;
            r_d_error <= 1'b0;
          end else begin
            // A Get with no rvalid still answers, flagged as error.
            r_d_data  <= '0;
            r_d_error <= r_is_get;
          end
        end
        ST_RESP: begin
          if (d_ready) begin
            r_d_valid <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_d_valid <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
